avg_pool_stream: RTL

Streaming 2×2/stride-2 average-pooling engine for FP16 (IEEE binary16) feature maps. It sits between a convolution layer's output stream and the next layer's input, consuming pixels row-major and channel-sequential. It buffers half a row of horizontal pair-sums and emits one pooled FP16 value per 2×2 window. The block generalises the combinational four-input averager into a sequential, parametrised, back-pressured unit.

---
 rtl/avg_pool_stream.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/avg_pool_stream.sv
// Streaming 2x2/stride-2 FP16 average pooling with valid/ready flow control.
// Optional AVG_POOL_RELU_EN: negative (and -0) results are clamped to +0.
module avg_pool_stream #(
    parameter int IMG_W    = 28,
    parameter int IMG_H    = 28,
    parameter int CHANNELS = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_last
);
    localparam int CW  = $clog2(IMG_W);
    localparam int RW  = $clog2(IMG_H);
    localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int LBW = (IMG_W / 2 > 1) ? $clog2(IMG_W / 2) : 1;

    // Subnormals flush to zero, RNE rounding, exact zero result is +0.
    function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
        logic        a_nan, b_nan, a_inf, b_inf, a_z, b_z, sticky, rnd;
        logic [15:0] x, y, r;
        logic [25:0] mx, my, mask, s;
        logic [4:0]  d;
        logic [10:0] m;
        int          e;
        a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
        b_nan = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
        a_inf = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
        b_inf = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
        a_z   = (a[14:10] == 5'd0);
        b_z   = (b[14:10] == 5'd0);
        r     = 16'h0000;
        if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) r = 16'h7E00;
        else if (a_inf)        r = a;
        else if (b_inf)        r = b;
        else if (a_z && b_z)   r = 16'h0000;
        else if (a_z)          r = b;
        else if (b_z)          r = a;
        else begin
            if (a[14:0] >= b[14:0]) begin x = a; y = b; end
            else                    begin x = b; y = a; end
            d      = x[14:10] - y[14:10];
            mx     = {2'b00, 1'b1, x[9:0], 13'd0};
            my     = {2'b00, 1'b1, y[9:0], 13'd0};
            mask   = (26'd1 << d) - 26'd1;
            sticky = |(my & mask);
            my     = (my >> d) | {25'd0, sticky};
            s      = (x[15] == y[15]) ? (mx + my) : (mx - my);
            if (s == 26'd0) r = 16'h0000;
            else begin
                e = int'(x[14:10]);
                if (s[24]) begin
                    s = {1'b0, s[25:1]} | {25'd0, s[0]};
                    e = e + 1;
                end
                for (int i = 0; i < 24; i++) begin
                    if (!s[23]) begin
                        s = s << 1;
                        e = e - 1;
                    end
                end
                rnd = s[12] & ((|s[11:0]) | s[13]);
                m   = {1'b0, s[22:13]} + {10'd0, rnd};
                if (m[10]) e = e + 1;
                if (e >= 31)     r = {x[15], 5'h1F, 10'd0};
                else if (e <= 0) r = {x[15], 15'd0};
                else             r = {x[15], 5'(e), m[9:0]};
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] fp16_div4(input logic [15:0] v);
        logic [15:0] r;
        if (v[14:10] == 5'h1F)      r = v;
        else if (v[14:10] <= 5'd2)  r = {v[15], 15'd0};
        else                        r = {v[15], v[14:10] - 5'd2, v[9:0]};
        return r;
    endfunction

    logic [CW-1:0]  r_col;
    logic [RW-1:0]  r_row;
    logic [CHW-1:0] r_ch;
    logic [15:0]    r_hold;
    logic [15:0]    r_lb [IMG_W/2];
    logic           r_out_valid, r_out_last;
    logic [15:0]    r_out_data;

    logic           w_in_hs, w_fire, w_last_pos;
    logic [LBW-1:0] w_lb_idx;
    logic [15:0]    w_pair, w_sum, w_avg, w_res;

    assign in_ready   = !r_out_valid || out_ready;
    assign w_in_hs    = in_valid && in_ready;
    assign w_lb_idx   = LBW'(r_col >> 1);
    assign w_pair     = fp16_add(r_hold, in_data);
    assign w_sum      = fp16_add(r_lb[w_lb_idx], w_pair);
    assign w_avg      = fp16_div4(w_sum);
    assign w_fire     = w_in_hs && r_col[0] && r_row[0];
    assign w_last_pos = (r_col == CW'(IMG_W - 1)) && (r_row == RW'(IMG_H - 1))
                     && (r_ch == CHW'(CHANNELS - 1));

`ifdef AVG_POOL_RELU_EN
    // NaN keeps its payload; everything else with the sign bit set becomes +0.
    assign w_res = (w_avg[15] && !((w_avg[14:10] == 5'h1F) && (w_avg[9:0] != 10'd0)))
                 ? 16'h0000 : w_avg;
`else
    assign w_res = w_avg;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col       <= '0;
            r_row       <= '0;
            r_ch        <= '0;
            r_hold      <= 16'h0000;
            r_out_valid <= 1'b0;
            r_out_data  <= 16'h0000;
            r_out_last  <= 1'b0;
        end else begin
            if (w_in_hs) begin
                if (!r_col[0]) r_hold <= in_data;
                if (r_col == CW'(IMG_W - 1)) begin
                    r_col <= '0;
                    if (r_row == RW'(IMG_H - 1)) begin
                        r_row <= '0;
                        r_ch  <= (r_ch == CHW'(CHANNELS - 1)) ? '0 : r_ch + 1'b1;
                    end else begin
                        r_row <= r_row + 1'b1;
                    end
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            if (w_fire) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_res;
                r_out_last  <= w_last_pos;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    // Every entry is written on an even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (w_in_hs && r_col[0] && !r_row[0]) r_lb[w_lb_idx] <= w_pair;
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
endmodule
